// File: rtl/matriz_max7219.sv
// MAX7219 8x8 LED matrix driver: sends the 5-word init sequence after reset,
// then one 8-row frame per accepted MTX_START, over a bit-banged 3-wire link.
module matriz_max7219 #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int CLKDIV        = 4,
  parameter int INTENSITY     = 8
) (
  input  logic                     MTX_CLOCK,
  input  logic                     MTX_RESET,
  input  logic [DATAWIDTH_BUS-1:0] MTX_7_IN,
  input  logic [DATAWIDTH_BUS-1:0] MTX_6_IN,
  input  logic [DATAWIDTH_BUS-1:0] MTX_5_IN,
  input  logic [DATAWIDTH_BUS-1:0] MTX_4_IN,
  input  logic [DATAWIDTH_BUS-1:0] MTX_3_IN,
  input  logic [DATAWIDTH_BUS-1:0] MTX_2_IN,
  input  logic [DATAWIDTH_BUS-1:0] MTX_1_IN,
  input  logic [DATAWIDTH_BUS-1:0] MTX_0_IN,
  input  logic                     MTX_START,
  output logic                     MTX_DIN,
  output logic                     MTX_SCLK,
  output logic                     MTX_LOAD,
  output logic                     MTX_BUSY,
  output logic                     MTX_DONE
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

  function automatic logic [15:0] init_word(input logic [2:0] idx);
    case (idx)
      3'd0:    init_word = 16'h0C01;
      3'd1:    init_word = 16'h0900;
      3'd2:    init_word = {8'h0A, 4'h0, 4'(INTENSITY)};
      3'd3:    init_word = 16'h0B07;
      3'd4:    init_word = 16'h0F00;
      default: init_word = 16'h0000;
    endcase
  endfunction

  logic [DATAWIDTH_BUS-1:0] w_in_rows [8];
  assign w_in_rows[0] = MTX_0_IN;
  assign w_in_rows[1] = MTX_1_IN;
  assign w_in_rows[2] = MTX_2_IN;
  assign w_in_rows[3] = MTX_3_IN;
  assign w_in_rows[4] = MTX_4_IN;
  assign w_in_rows[5] = MTX_5_IN;
  assign w_in_rows[6] = MTX_6_IN;
  assign w_in_rows[7] = MTX_7_IN;

  state_t                   r_state, w_state;
  logic [7:0]               r_div, w_div;
  logic                     r_half, w_half;
  logic [3:0]               r_bit, w_bit;
  logic [2:0]               r_word, w_word;
  logic                     r_init, w_init;
  logic [15:0]              r_shreg, w_shreg;
  logic [DATAWIDTH_BUS-1:0] r_rows [8];
  logic                     w_snap, w_done, w_last;
  logic [2:0]               w_word_inc;
  logic                     r_din, r_sclk, r_load, r_busy, r_done;

  assign w_word_inc = r_word + 3'd1;
  assign w_last     = r_init ? (r_word == 3'd4) : (r_word == 3'd7);

  // Next-state logic: half-period divider, bit/word counters and shift register
  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_half  = r_half;
    w_bit   = r_bit;
    w_word  = r_word;
    w_init  = r_init;
    w_shreg = r_shreg;
    w_snap  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      INIT: begin
        w_state = SHIFT;
        w_init  = 1'b1;
        w_word  = 3'd0;
        w_div   = 8'd0;
        w_half  = 1'b0;
        w_bit   = 4'd0;
        w_shreg = init_word(3'd0);
      end
      IDLE: begin
        if (MTX_START) begin
          w_state = SHIFT;
          w_init  = 1'b0;
          w_word  = 3'd0;
          w_div   = 8'd0;
          w_half  = 1'b0;
          w_bit   = 4'd0;
          w_snap  = 1'b1;
          w_shreg = {8'h01, 8'(w_in_rows[0])};
        end else begin
          w_state = IDLE;
        end
      end
      SHIFT: begin
        if (r_div == DIV_LAST) begin
          w_div = 8'd0;
          if (!r_half) begin
            w_half = 1'b1;
          end else begin
            w_half = 1'b0;
            if (r_bit == 4'd15) begin
              w_bit   = 4'd0;
              w_state = GAP;
            end else begin
              w_bit   = r_bit + 4'd1;
              w_shreg = {r_shreg[14:0], 1'b0};
            end
          end
        end else begin
          w_div = r_div + 8'd1;
        end
      end
      GAP: begin
        if (r_div == DIV_LAST) begin
          w_div = 8'd0;
          if (!r_half) begin
            w_half = 1'b1;
          end else begin
            w_half = 1'b0;
            if (w_last) begin
              w_state = IDLE;
              w_done  = !r_init;
            end else begin
              w_state = SHIFT;
              w_word  = w_word_inc;
              if (r_init) begin
                w_shreg = init_word(w_word_inc);
              end else begin
                w_shreg = {8'({1'b0, w_word_inc} + 4'd1), 8'(r_rows[w_word_inc])};
              end
            end
          end
        end else begin
          w_div = r_div + 8'd1;
        end
      end
      default: begin
        w_state = INIT;
      end
    endcase
  end

  // State, snapshot and output registers; outputs decode the next state so
  // they line up with the state they describe
  always_ff @(posedge MTX_CLOCK or posedge MTX_RESET) begin
    if (MTX_RESET) begin
      r_state <= INIT;
      r_div   <= 8'd0;
      r_half  <= 1'b0;
      r_bit   <= 4'd0;
      r_word  <= 3'd0;
      r_init  <= 1'b0;
      r_shreg <= 16'h0000;
      for (int i = 0; i < 8; i++) r_rows[i] <= '0;
      r_din   <= 1'b0;
      r_sclk  <= 1'b0;
      r_load  <= 1'b1;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_half  <= w_half;
      r_bit   <= w_bit;
      r_word  <= w_word;
      r_init  <= w_init;
      r_shreg <= w_shreg;
      if (w_snap) r_rows <= w_in_rows;
      r_din   <= (w_state == SHIFT) && w_shreg[15];
      r_sclk  <= (w_state == SHIFT) && w_half;
      r_load  <= (w_state != SHIFT);
      r_busy  <= (w_state != IDLE);
      r_done  <= w_done;
    end
  end

  assign MTX_DIN  = r_din;
  assign MTX_SCLK = r_sclk;
  assign MTX_LOAD = r_load;
  assign MTX_BUSY = r_busy;
  assign MTX_DONE = r_done;

endmodule

// File: tb/tb_matriz_max7219.sv
// Bench for matriz_max7219: an SPI monitor decodes words into a queue that is
// checked against a scoreboard of expected words plus timing checks.
module tb_matriz_max7219;
  localparam int CLKDIV     = 4;
  localparam int WORD_CLKS  = 34 * CLKDIV;
  localparam int INIT_CLKS  = 5 * WORD_CLKS;
  localparam int FRAME_CLKS = 8 * WORD_CLKS;

  typedef struct {
    logic [7:0]  rows  [8];
    logic [15:0] words [8];
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rows_in [8];
  logic       din, sclk, load, busy, done;

  always #5 clk = ~clk;

  matriz_max7219 #(.DATAWIDTH_BUS(8), .CLKDIV(CLKDIV), .INTENSITY(8)) dut (
    .MTX_CLOCK(clk), .MTX_RESET(rst),
    .MTX_7_IN(rows_in[7]), .MTX_6_IN(rows_in[6]), .MTX_5_IN(rows_in[5]),
    .MTX_4_IN(rows_in[4]), .MTX_3_IN(rows_in[3]), .MTX_2_IN(rows_in[2]),
    .MTX_1_IN(rows_in[1]), .MTX_0_IN(rows_in[0]),
    .MTX_START(start), .MTX_DIN(din), .MTX_SCLK(sclk), .MTX_LOAD(load),
    .MTX_BUSY(busy), .MTX_DONE(done)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q [$];
  logic [31:0] rx_q [$];
  int          rx_bits = 0;
  logic [15:0] rx_sh = 16'h0000;
  int          done_cnt = 0;
  int          line_viol = 0;
  logic        p_sclk = 1'b0;
  logic        p_load = 1'b1;

  // SPI monitor: shift DIN on SCLK rise, emit {bit count, word} on LOAD rise
  always @(negedge clk) begin
    if (rst) begin
      rx_bits = 0;
    end else begin
      if (sclk && !p_sclk) begin
        rx_sh = {rx_sh[14:0], din};
        rx_bits++;
      end
      if (load && !p_load) begin
        rx_q.push_back({rx_bits[15:0], rx_sh});
        rx_bits = 0;
      end
      if (load && (sclk || din)) line_viol++;
      if (done) done_cnt++;
    end
    p_sclk = sclk;
    p_load = load;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit strict);
    logic [31:0] r;
    logic [15:0] e;
    while (rx_q.size() > 0) begin
      r = rx_q.pop_front();
      check("bits_per_word", {16'h0000, r[31:16]}, 32'd16);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_word: got %04h, required no word", r[15:0]);
      end else begin
        e = exp_q.pop_front();
        check("word", {16'h0000, r[15:0]}, {16'h0000, e});
      end
    end
    if (strict) check("missing_words", exp_q.size(), 32'd0);
    exp_q.delete();
    check("idle_line_violations", line_viol, 32'd0);
  endtask

  task automatic do_init(input bit poke);
    int lat;
    int d0;
    d0 = done_cnt;
    exp_q.push_back(16'h0C01);
    exp_q.push_back(16'h0900);
    exp_q.push_back(16'h0A08);
    exp_q.push_back(16'h0B07);
    exp_q.push_back(16'h0F00);
    rst = 1'b0;
    tick();
    lat = 0;
    while (busy && lat < INIT_CLKS + 100) begin
      start = poke && (lat == 100 || lat == 101);
      tick();
      lat++;
    end
    start = 1'b0;
    check("init_busy_fall", lat, INIT_CLKS);
    repeat (4) tick();
    check("idle_outputs", {28'h0, busy, load, sclk, din}, 32'h4);
    check("init_no_done", done_cnt - d0, 32'd0);
    drain(1'b1);
  endtask

  task automatic run_frame(input vec_t v, input int poke_at, input bit scramble);
    int lat;
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < 8; k++) begin
      rows_in[k] = v.rows[k];
      exp_q.push_back(v.words[k]);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    if (scramble) for (int k = 0; k < 8; k++) rows_in[k] = 8'hFF;
    check("busy_rise", {31'h0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < FRAME_CLKS + 100) begin
      start = (lat == poke_at);
      tick();
      lat++;
    end
    start = 1'b0;
    check("done_latency", lat, FRAME_CLKS);
    check("busy_fall_on_done", {31'h0, busy}, 32'd0);
    tick();
    check("done_one_cycle", {31'h0, done}, 32'd0);
    check("done_count", done_cnt - d0, 32'd1);
    drain(1'b1);
  endtask

  vec_t tab [5];

  initial begin
    int   lat;
    bit   found;
    for (int k = 0; k < 8; k++) rows_in[k] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_load", {31'h0, load}, 32'd1);
    check("reset_sclk", {31'h0, sclk}, 32'd0);
    check("reset_din",  {31'h0, din},  32'd0);
    check("reset_busy", {31'h0, busy}, 32'd1);
    check("reset_done", {31'h0, done}, 32'd0);

    do_init(1'b1);

    for (int k = 0; k < 8; k++) begin
      tab[0].rows[k] = 8'h01 << k;
      tab[1].rows[k] = 8'h00;
      tab[2].rows[k] = 8'hFF;
      tab[3].rows[k] = k[0] ? 8'h5A : 8'hA5;
      tab[4].rows[k] = 8'($urandom);
    end
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 8; k++)
        tab[i].words[k] = {8'(k + 1), tab[i].rows[k]};

    for (int i = 0; i < 5; i++) run_frame(tab[i], -1, 1'b0);

    run_frame(tab[3], -1, 1'b1);
    run_frame(tab[0], 300, 1'b0);

    // START held high: two back-to-back frames, then release
    for (int k = 0; k < 8; k++) rows_in[k] = tab[3].rows[k];
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 8; k++) exp_q.push_back(tab[3].words[k]);
    start = 1'b1;
    tick();
    lat = 0;
    while (!done && lat < FRAME_CLKS + 100) begin tick(); lat++; end
    check("b2b_first_done", lat, FRAME_CLKS);
    tick();
    lat = 1;
    while (!done && lat < FRAME_CLKS + 100) begin tick(); lat++; end
    check("b2b_done_spacing", lat, FRAME_CLKS + 1);
    start = 1'b0;
    tick();
    tick();
    check("b2b_stops", {31'h0, busy}, 32'd0);
    drain(1'b1);

    // Reset in the middle of word 3, bit 7
    for (int k = 0; k < 8; k++) begin
      rows_in[k] = tab[0].rows[k];
      exp_q.push_back(tab[0].words[k]);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < FRAME_CLKS && !found; c++) begin
      @(negedge clk);
      if (rx_q.size() == 3 && rx_bits == 7) found = 1'b1;
    end
    check("reached_word3_bit7", {31'h0, found}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_outputs", {27'h0, load, sclk, din, busy, done}, 32'h12);
    drain(1'b0);
    repeat (3) tick();
    check("busy_in_reset", {31'h0, busy}, 32'd1);
    do_init(1'b0);
    run_frame(tab[0], -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
